// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: 2-read / 2-write register file with per-register busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (port B over port A) to the read ports.
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rs,
   input  logic [ADDR_W-1:0] rt,
   input  logic [ADDR_W-1:0] rd,
   input  logic              RegDst,
   input  logic              RegWre,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] waddr_b,
   input  logic [DATA_W-1:0] wdata_b,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              busy1,
   output logic              busy2,
   output logic              stall
);
   localparam int DEPTH = 2**ADDR_W;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0] busy;
   logic [ADDR_W-1:0] waddr_a;
   logic wen_a, wen_b, set_busy;
   logic [1:0][ADDR_W-1:0] raddr;
   logic [1:0][DATA_W-1:0] rdata;
   logic [1:0] rbusy;
   assign waddr_a  = RegDst ? rd : rt;
   // writes and issues aimed at a hardwired-zero r0 are dropped here, so r0/busy[0] never change
   assign wen_a    = RegWre && !(ZERO_REG && waddr_a == '0);
   assign wen_b    = we_b && !(ZERO_REG && waddr_b == '0);
   assign set_busy = issue_en && !(ZERO_REG && issue_addr == '0);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         busy <= '0;
      end else begin
         if (wen_a) regs[waddr_a] <= wdata_a;
         if (wen_b) regs[waddr_b] <= wdata_b;
         if (wen_b) busy[waddr_b] <= 1'b0;
         // a new producer supersedes the one completing on port B
         if (set_busy) busy[issue_addr] <= 1'b1;
      end
   end
   assign raddr = {rt, rs};
   for (genvar i = 0; i < 2; i++) begin : g_rd
      logic zero, fwd_a, fwd_b;
      assign zero = ZERO_REG && raddr[i] == '0;
`ifdef REGFILE_BYPASS_EN
      assign fwd_b = wen_b && waddr_b == raddr[i];
      assign fwd_a = wen_a && waddr_a == raddr[i];
`else
      assign fwd_b = 1'b0;
      assign fwd_a = 1'b0;
`endif
      assign rdata[i] = zero ? '0 : fwd_b ? wdata_b : fwd_a ? wdata_a : regs[raddr[i]];
      assign rbusy[i] = !zero && !fwd_b && busy[raddr[i]];
   end
   assign read_data1 = rdata[0];
   assign read_data2 = rdata[1];
   assign busy1      = rbusy[0];
   assign busy2      = rbusy[1];
   assign stall      = rbusy[0] | rbusy[1];
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: scoreboard bench for regfile_mp_sb (default parameters, ZERO_REG=1).
// Follows REGFILE_BYPASS_EN to pick the expected same-cycle read behaviour.
module tb_regfile_mp_sb;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rs, rt, rd, waddr_b, issue_addr;
   logic        RegDst, RegWre, we_b, issue_en;
   logic [31:0] wdata_a, wdata_b;
   logic [31:0] read_data1, read_data2;
   logic        busy1, busy2, stall;
   typedef struct {string n; logic [66:0] v;} exp_t;
   exp_t q[$];
   int total = 0;
   int bad = 0;
   logic [31:0] mem [32];
   logic        mb  [32];
   regfile_mp_sb dut (
      .clk(clk), .rst_n(rst_n), .rs(rs), .rt(rt), .rd(rd), .RegDst(RegDst), .RegWre(RegWre),
      .wdata_a(wdata_a), .we_b(we_b), .waddr_b(waddr_b), .wdata_b(wdata_b),
      .issue_en(issue_en), .issue_addr(issue_addr), .read_data1(read_data1),
      .read_data2(read_data2), .busy1(busy1), .busy2(busy2), .stall(stall)
   );
   always #5 clk = ~clk;
   task automatic idle;
      rs = '0; rt = '0; rd = '0; RegDst = 1'b0; RegWre = 1'b0; wdata_a = '0;
      we_b = 1'b0; waddr_b = '0; wdata_b = '0; issue_en = 1'b0; issue_addr = '0;
   endtask
   // reference state advances with the inputs present at the coming edge
   task automatic step;
      logic [4:0] wa;
      wa = RegDst ? rd : rt;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin mem[i] = '0; mb[i] = 1'b0; end
      end else begin
         if (RegWre && wa != 0) mem[wa] = wdata_a;
         if (we_b && waddr_b != 0) begin mem[waddr_b] = wdata_b; mb[waddr_b] = 1'b0; end
         if (issue_en && issue_addr != 0) mb[issue_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask
   function automatic logic [31:0] exp_data(input logic [4:0] a);
      logic [4:0] wa;
      wa = RegDst ? rd : rt;
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we_b && waddr_b == a) return wdata_b;
      if (RegWre && wa == a) return wdata_a;
`endif
      return mem[a];
   endfunction
   function automatic logic exp_busy(input logic [4:0] a);
      if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
      if (we_b && waddr_b == a) return 1'b0;
`endif
      return mb[a];
   endfunction
   task automatic test_reset;
      exp_t e;
      idle;
      RegWre = 1'b1; RegDst = 1'b1; rd = 5'd5; wdata_a = 32'hDEADBEEF;
      issue_en = 1'b1; issue_addr = 5'd5;
      step;
      idle; rs = 5'd5; rt = 5'd5;
      q.push_back('{"pre_reset_r5", {32'hDEADBEEF, 32'hDEADBEEF, 3'b111}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      rst_n = 1'b0; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd8; wdata_a = 32'h1234;
      issue_en = 1'b1; issue_addr = 5'd8;
      step;
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) begin
         idle; rs = 5'(a); rt = 5'(31 - a);
         q.push_back('{$sformatf("reset_r%0d", a), 67'h0});
         #1;
         e = q.pop_front(); total++;
         if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
            bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
         end
      end
   endtask
   task automatic test_port_a;
      exp_t e;
      idle; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd3; rt = 5'd7; wdata_a = 32'h11;
      step;
      idle; rs = 5'd3; rt = 5'd7;
      q.push_back('{"regdst1", {32'h11, 32'h0, 3'b000}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      idle; RegWre = 1'b1; RegDst = 1'b0; rd = 5'd3; rt = 5'd7; wdata_a = 32'h22;
      step;
      idle; rs = 5'd3; rt = 5'd7;
      q.push_back('{"regdst0", {32'h11, 32'h22, 3'b000}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
   endtask
   task automatic test_zero_reg;
      exp_t e;
      idle; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd0; wdata_a = 32'hFFFF_FFFF;
      we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFF_FFFF; issue_en = 1'b1; issue_addr = 5'd0;
      step;
      idle; rs = 5'd0; rt = 5'd0;
      q.push_back('{"zero_reg", 67'h0});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
   endtask
   task automatic test_collision;
      exp_t e;
      idle; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd9; wdata_a = 32'hAAAA;
      we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'hBBBB;
      step;
      idle; rs = 5'd9; rt = 5'd9;
      q.push_back('{"ab_same_reg", {32'hBBBB, 32'hBBBB, 3'b000}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
   endtask
   task automatic test_scoreboard;
      exp_t e;
      idle; issue_en = 1'b1; issue_addr = 5'd4;
      step;
      idle; rs = 5'd4;
      q.push_back('{"issued", {32'h0, 32'h0, 3'b101}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      idle; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd4; wdata_a = 32'h77; issue_en = 1'b1; issue_addr = 5'd4;
      step;
      idle; rs = 5'd4;
      q.push_back('{"a_keeps_busy", {32'h77, 32'h0, 3'b101}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      idle; we_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h42;
      step;
      idle; rs = 5'd4;
      q.push_back('{"b_clears_busy", {32'h42, 32'h0, 3'b000}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      idle; we_b = 1'b1; waddr_b = 5'd4; wdata_b = 32'h42; issue_en = 1'b1; issue_addr = 5'd4;
      step;
      idle; rt = 5'd4;
      q.push_back('{"set_beats_clear", {32'h0, 32'h42, 3'b011}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
   endtask
   task automatic test_bypass;
      exp_t e;
      idle; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd6; wdata_a = 32'h10; issue_en = 1'b1; issue_addr = 5'd6;
      step;
      idle; rs = 5'd6; we_b = 1'b1; waddr_b = 5'd6; wdata_b = 32'h55;
`ifdef REGFILE_BYPASS_EN
      q.push_back('{"same_cycle_b", {32'h55, 32'h0, 3'b000}});
`else
      q.push_back('{"same_cycle_b", {32'h10, 32'h0, 3'b101}});
`endif
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      step;
      idle; rt = 5'd6; RegWre = 1'b1; RegDst = 1'b1; rd = 5'd6; wdata_a = 32'h66;
`ifdef REGFILE_BYPASS_EN
      q.push_back('{"same_cycle_a", {32'h0, 32'h66, 3'b000}});
`else
      q.push_back('{"same_cycle_a", {32'h0, 32'h55, 3'b000}});
`endif
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
      step;
      idle; rs = 5'd6;
      q.push_back('{"after_edge", {32'h66, 32'h0, 3'b000}});
      #1;
      e = q.pop_front(); total++;
      if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
         bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
      end
   endtask
   task automatic test_back_to_back;
      exp_t e;
      logic [31:0] d1, d2;
      logic b1, b2;
      for (int c = 0; c < 400; c++) begin
         rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
         RegDst = 1'($urandom); RegWre = 1'($urandom); wdata_a = $urandom;
         we_b = 1'($urandom); waddr_b = 5'($urandom_range(0, 7)); wdata_b = $urandom;
         issue_en = 1'($urandom); issue_addr = 5'($urandom_range(0, 7));
         d1 = exp_data(rs); d2 = exp_data(rt); b1 = exp_busy(rs); b2 = exp_busy(rt);
         q.push_back('{$sformatf("rand_c%0d", c), {d1, d2, b1, b2, b1 | b2}});
         #1;
         e = q.pop_front(); total++;
         if ({read_data1, read_data2, busy1, busy2, stall} !== e.v) begin
            bad++; $display("FAIL %s got=%h want=%h", e.n, {read_data1, read_data2, busy1, busy2, stall}, e.v);
         end
         step;
      end
   endtask
   initial begin
      idle;
      rst_n = 1'b0;
      step;
      step;
      rst_n = 1'b1;
      test_reset;
      test_port_a;
      test_zero_reg;
      test_collision;
      test_scoreboard;
      test_bypass;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
